// File: rtl/cache_controller.sv
// Direct-mapped, write-back, write-allocate cache controller sitting between a
// CPU word port, an external tag/data array and a line-wide DDR interface.
module cache_controller #(
  parameter int ADDR_WIDTH   = 28,
  parameter int DATA_WIDTH   = 32,
  parameter int BLOCK_SIZE   = 256,
  parameter int CACHE_SIZE   = 65536,
  localparam int NUM_BLOCKS   = CACHE_SIZE * 8 / BLOCK_SIZE,
  localparam int OFFSET_WIDTH = $clog2(BLOCK_SIZE / DATA_WIDTH),
  localparam int INDEX_WIDTH  = $clog2(NUM_BLOCKS),
  localparam int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic                  cpu_re,
  input  logic                  cpu_we,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ready,
  output logic [ADDR_WIDTH-1:0] cm_addr,
  output logic [BLOCK_SIZE-1:0] cm_data_write,
  output logic                  cm_dirty_write,
  output logic                  cm_write_en,
  input  logic [BLOCK_SIZE-1:0] cm_data_read,
  input  logic                  cm_dirty_read,
  input  logic                  cm_hit,
  input  logic [TAG_WIDTH-1:0]  cm_replace_tag,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [BLOCK_SIZE-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [BLOCK_SIZE-1:0] mem_rdata,
  input  logic                  mem_ack
);

  typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE, INSTALL} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    store_q;
  logic [BLOCK_SIZE-1:0]   fill_q;
  logic [NUM_BLOCKS-1:0]   valid_q;

  logic [TAG_WIDTH-1:0]    tag;
  logic [INDEX_WIDTH-1:0]  index;
  logic [OFFSET_WIDTH-1:0] offset;
  logic                    request;
  logic                    victim_dirty;

  assign {tag, index, offset} = addr_q;
  assign cm_addr              = addr_q;
  assign request              = cpu_re | cpu_we;
  assign victim_dirty         = valid_q[index] & cm_dirty_read;

  function automatic logic [DATA_WIDTH-1:0] get_word(input logic [BLOCK_SIZE-1:0]   line,
                                                     input logic [OFFSET_WIDTH-1:0] w);
    return line[int'(w) * DATA_WIDTH +: DATA_WIDTH];
  endfunction

  function automatic logic [BLOCK_SIZE-1:0] put_word(input logic [BLOCK_SIZE-1:0]   line,
                                                     input logic [OFFSET_WIDTH-1:0] w,
                                                     input logic [DATA_WIDTH-1:0]   data);
    logic [BLOCK_SIZE-1:0] merged;
    merged = line;
    merged[int'(w) * DATA_WIDTH +: DATA_WIDTH] = data;
    return merged;
  endfunction

  // NOTE: valid_q is the only trusted validity record; the array contents and
  // its dirty bits are deliberately left unreset, so valid_q gates every use.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      store_q <= 1'b0;
      fill_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && request) begin
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
        store_q <= cpu_we;
      end
      if (state_q == ALLOCATE && mem_ack) fill_q <= mem_rdata;
      if (state_q == INSTALL) valid_q[index] <= 1'b1;
    end
  end

  // NOTE: every combinational output gets a default first so no path through
  // the case statement can leave a latch behind.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (request) state_d = COMPARE;
      COMPARE: begin
        if (cm_hit)            state_d = IDLE;
        else if (victim_dirty) state_d = WRITEBACK;
        else                   state_d = ALLOCATE;
      end
      WRITEBACK: if (mem_ack) state_d = ALLOCATE;
      ALLOCATE:  if (mem_ack) state_d = INSTALL;
      INSTALL:   state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_ready      = 1'b0;
    cpu_rdata      = '0;
    cm_write_en    = 1'b0;
    cm_data_write  = '0;
    cm_dirty_write = 1'b0;
    mem_we         = 1'b0;
    mem_re         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    case (state_q)
      COMPARE: begin
        if (cm_hit) begin
          cpu_ready = 1'b1;
          if (store_q) begin
            cm_write_en    = 1'b1;
            cm_data_write  = put_word(cm_data_read, offset, wdata_q);
            cm_dirty_write = 1'b1;
          end else begin
            cpu_rdata = get_word(cm_data_read, offset);
          end
        end
      end
      WRITEBACK: begin
        mem_we    = 1'b1;
        mem_addr  = {cm_replace_tag, index, {OFFSET_WIDTH{1'b0}}};
        mem_wdata = cm_data_read;
      end
      ALLOCATE: begin
        mem_re   = 1'b1;
        mem_addr = {tag, index, {OFFSET_WIDTH{1'b0}}};
      end
      INSTALL: begin
        cm_write_en    = 1'b1;
        cm_data_write  = store_q ? put_word(fill_q, offset, wdata_q) : fill_q;
        cm_dirty_write = store_q;
        cpu_ready      = 1'b1;
        cpu_rdata      = store_q ? '0 : get_word(fill_q, offset);
      end
      default: ;
    endcase
    // A request interrupted by reset must never commit to the array or the CPU.
    if (rst) begin
      cpu_ready      = 1'b0;
      cpu_rdata      = '0;
      cm_write_en    = 1'b0;
      cm_data_write  = '0;
      cm_dirty_write = 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: behavioural tag/data array and DDR,
// directed vector table, randomized traffic against a word-level memory model.
module tb_cache_controller;
  localparam int AW = 28, DW = 32, BW = 256, TW = 14, IW = 11, OW = 3, NB = 2048;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_re = 1'b0, cpu_we = 1'b0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ready;
  logic [AW-1:0] cm_addr;
  logic [BW-1:0] cm_data_write, cm_data_read;
  logic          cm_dirty_write, cm_write_en, cm_dirty_read, cm_hit;
  logic [TW-1:0] cm_replace_tag;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_wdata;
  logic          mem_we, mem_re;
  logic [BW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  cache_controller dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .cm_addr(cm_addr), .cm_data_write(cm_data_write), .cm_dirty_write(cm_dirty_write),
    .cm_write_en(cm_write_en), .cm_data_read(cm_data_read), .cm_dirty_read(cm_dirty_read),
    .cm_hit(cm_hit), .cm_replace_tag(cm_replace_tag), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Default DDR content: word k of line L is (L << 8) + k.
  function automatic logic [DW-1:0] dflt_word(input logic [AW-1:0] a);
    logic [DW-1:0] line;
    line = DW'({a[AW-1:OW], {OW{1'b0}}});
    return (line << 8) + DW'(a[OW-1:0]);
  endfunction

  function automatic logic [BW-1:0] put_word(input logic [BW-1:0] line, input int k,
                                             input logic [DW-1:0] d);
    logic [BW-1:0] r;
    r = line;
    r[k*DW +: DW] = d;
    return r;
  endfunction

  function automatic logic [BW-1:0] dflt_line(input logic [AW-1:0] a);
    logic [BW-1:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r = put_word(r, k, dflt_word({a[AW-1:OW], OW'(k)}));
    return r;
  endfunction

  // Tag/data array: combinational read at cm_addr, synchronous write.
  logic [BW-1:0] arr_data [NB];
  logic [TW-1:0] arr_tag [NB];
  logic          arr_dirty [NB];
  logic          arr_valid [NB];
  logic          arr_clear = 1'b1;
  logic [IW-1:0] arr_idx;

  assign arr_idx        = cm_addr[OW +: IW];
  assign cm_data_read   = arr_data[arr_idx];
  assign cm_dirty_read  = arr_dirty[arr_idx];
  assign cm_replace_tag = arr_tag[arr_idx];
  assign cm_hit         = arr_valid[arr_idx] && (arr_tag[arr_idx] == cm_addr[AW-1 -: TW]);

  always @(posedge clk) begin
    if (arr_clear) begin
      for (int i = 0; i < NB; i++) begin
        arr_valid[i] <= 1'b0;
        arr_dirty[i] <= 1'b1;
        arr_tag[i]   <= '1;
        arr_data[i]  <= {8{32'hBADC0DE5}};
      end
    end else if (cm_write_en) begin
      arr_data[arr_idx]  <= cm_data_write;
      arr_dirty[arr_idx] <= cm_dirty_write;
      arr_tag[arr_idx]   <= cm_addr[AW-1 -: TW];
      arr_valid[arr_idx] <= 1'b1;
    end
  end

  // DDR: acks each request after a configurable number of wait cycles.
  logic [BW-1:0] ddr [logic [AW-1:0]];
  int            ddr_wait_cfg = 0;
  bit            ddr_auto = 1'b1, ack_force = 1'b0, ddr_busy = 1'b0;
  int            ddr_cnt = 0, ddr_target = 0;
  int            n_wb = 0, n_rd = 0, wb_wait = 0, rd_wait = 0;
  logic [AW-1:0] wb_addr = '0, rd_addr = '0;
  logic [BW-1:0] wb_line = '0;

  function automatic logic [BW-1:0] ddr_line(input logic [AW-1:0] a);
    if (ddr.exists(a)) return ddr[a];
    return dflt_line(a);
  endfunction

  always @(negedge clk) begin
    if (!ddr_auto) begin
      mem_ack  = ack_force;
      ddr_busy = 1'b0;
    end else begin
      if (mem_ack) begin
        mem_ack  = 1'b0;
        ddr_busy = 1'b0;
      end
      if (mem_re || mem_we) begin
        if (!ddr_busy) begin
          ddr_busy   = 1'b1;
          ddr_cnt    = 0;
          ddr_target = (ddr_wait_cfg < 0) ? int'($urandom_range(0, 3)) : ddr_wait_cfg;
          if (mem_we) wb_wait = ddr_target;
          else        rd_wait = ddr_target;
        end
        if (ddr_cnt == ddr_target) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            ddr[mem_addr] = mem_wdata;
            wb_addr = mem_addr;
            wb_line = mem_wdata;
            n_wb++;
          end else begin
            mem_rdata = ddr_line(mem_addr);
            rd_addr   = mem_addr;
            n_rd++;
          end
        end else begin
          ddr_cnt++;
        end
      end
    end
  end

  // Output monitor: strobes, protocol invariants.
  int            n_wr = 0, n_ready = 0, n_req_cyc = 0, excl_bad = 0, rdata_bad = 0;
  logic [BW-1:0] wr_line = '0;
  logic          wr_dirty = 1'b0;

  always @(negedge clk) begin
    if (mem_re && mem_we) excl_bad++;
    if (!cpu_ready && cpu_rdata != '0) rdata_bad++;
    if (mem_re || mem_we) n_req_cyc++;
    if (cpu_ready) n_ready++;
    if (cm_write_en) begin
      n_wr++;
      wr_line  = cm_data_write;
      wr_dirty = cm_dirty_write;
    end
  end

  typedef struct {
    logic [DW-1:0] rdata;
    int            lat, nwb, nrd, nwr, nreq;
    logic [BW-1:0] wr_line, wb_line;
    logic          wr_dirty;
    logic [AW-1:0] wb_addr, rd_addr;
    int            wb_wait, rd_wait;
  } res_t;

  task automatic do_req(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] d,
                        output res_t r);
    int wb0, rd0, wr0, rq0;
    @(negedge clk);
    #1;
    wb0 = n_wb; rd0 = n_rd; wr0 = n_wr; rq0 = n_req_cyc;
    cpu_addr = a; cpu_wdata = d; cpu_we = we; cpu_re = !we;
    @(negedge clk);
    cpu_re = 1'b0; cpu_we = 1'b0;
    r.lat = 1;
    while (!cpu_ready && r.lat < 100) begin
      @(negedge clk);
      r.lat++;
    end
    #1;
    check("req_done", cpu_ready, 1);
    r.rdata    = cpu_rdata;
    r.nwb      = n_wb - wb0;
    r.nrd      = n_rd - rd0;
    r.nwr      = n_wr - wr0;
    r.nreq     = n_req_cyc - rq0;
    r.wr_line  = wr_line;
    r.wr_dirty = wr_dirty;
    r.wb_addr  = wb_addr;
    r.wb_line  = wb_line;
    r.rd_addr  = rd_addr;
    r.wb_wait  = wb_wait;
    r.rd_wait  = rd_wait;
  endtask

  // Reference model: flat word memory plus per-index residency/dirty record.
  logic [DW-1:0] ref_word [logic [AW-1:0]];
  int            ref_tag [int];
  bit            ref_dirty [int];

  function automatic void ref_access(input logic [AW-1:0] a, input logic we,
                                     input logic [DW-1:0] d, output bit hit,
                                     output bit wb, output logic [DW-1:0] rdata);
    int idx, tg;
    idx = int'(a[OW +: IW]);
    tg  = int'(a[AW-1 -: TW]);
    hit = ref_tag.exists(idx) && ref_tag[idx] == tg;
    wb  = !hit && ref_tag.exists(idx) && ref_dirty[idx];
    if (!hit) begin
      ref_tag[idx]   = tg;
      ref_dirty[idx] = 1'b0;
    end
    if (we) begin
      ref_dirty[idx] = 1'b1;
      ref_word[a]    = d;
      rdata          = '0;
    end else begin
      rdata = ref_word.exists(a) ? ref_word[a] : dflt_word(a);
    end
  endfunction

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    int            wait_c;
    logic [DW-1:0] exp_rdata;
    int            exp_lat, exp_wb;
    logic [AW-1:0] exp_wb_addr;
    logic [BW-1:0] exp_wb_line;
    int            exp_rd;
    logic [AW-1:0] exp_rd_addr;
    int            exp_wr;
    logic [BW-1:0] exp_wr_line;
    logic          exp_wr_dirty;
  } vec_t;

  function automatic vec_t mkv(logic [AW-1:0] a, logic we, logic [DW-1:0] d, int w,
                               logic [DW-1:0] er, int lat, int nwb, logic [AW-1:0] wba,
                               logic [BW-1:0] wbl, int nrd, logic [AW-1:0] rda, int nwr,
                               logic [BW-1:0] wrl, logic wrd);
    vec_t v;
    v.addr = a; v.we = we; v.wdata = d; v.wait_c = w; v.exp_rdata = er; v.exp_lat = lat;
    v.exp_wb = nwb; v.exp_wb_addr = wba; v.exp_wb_line = wbl; v.exp_rd = nrd;
    v.exp_rd_addr = rda; v.exp_wr = nwr; v.exp_wr_line = wrl; v.exp_wr_dirty = wrd;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench did not terminate in time");
  end

  initial begin
    vec_t          vecs[5];
    res_t          r;
    bit            hit, wb;
    logic [DW-1:0] er;
    logic [BW-1:0] line10, line10s;
    int            wr0, rdy0, exp_lat;

    line10  = dflt_line(28'h0000010);
    line10s = put_word(line10, 2, 32'hDEADBEEF);
    vecs[0] = mkv(28'h0000013, 1'b0, '0, 2, 32'h1003, 5, 0, '0, '0,
                  1, 28'h0000010, 1, line10, 1'b0);
    vecs[1] = mkv(28'h0000015, 1'b0, '0, 0, 32'h1005, 1, 0, '0, '0,
                  0, '0, 0, '0, 1'b0);
    vecs[2] = mkv(28'h0000012, 1'b1, 32'hDEADBEEF, 0, '0, 1, 0, '0, '0,
                  0, '0, 1, line10s, 1'b1);
    vecs[3] = mkv(28'h0004010, 1'b0, '0, 1, 32'h00401000, 6, 1, 28'h0000010, line10s,
                  1, 28'h0004010, 1, dflt_line(28'h0004010), 1'b0);
    vecs[4] = mkv(28'h0000028, 1'b1, 32'hCAFEF00D, 0, '0, 3, 0, '0, '0,
                  1, 28'h0000028, 1, put_word(dflt_line(28'h0000028), 0, 32'hCAFEF00D), 1'b1);

    repeat (3) @(negedge clk);
    check("rst_cpu_ready", cpu_ready, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_cm_write_en", cm_write_en, 0);
    check("rst_cm_addr", cm_addr, 0);
    check("rst_cm_data_write", cm_data_write, 0);
    check("rst_mem_re", mem_re, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    rst = 1'b0;
    arr_clear = 1'b0;

    foreach (vecs[i]) begin
      ddr_wait_cfg = vecs[i].wait_c;
      ref_access(vecs[i].addr, vecs[i].we, vecs[i].wdata, hit, wb, er);
      do_req(vecs[i].addr, vecs[i].we, vecs[i].wdata, r);
      check($sformatf("v%0d_lat", i), r.lat, vecs[i].exp_lat);
      check($sformatf("v%0d_nwb", i), r.nwb, vecs[i].exp_wb);
      check($sformatf("v%0d_nrd", i), r.nrd, vecs[i].exp_rd);
      check($sformatf("v%0d_nwr", i), r.nwr, vecs[i].exp_wr);
      if (!vecs[i].we) check($sformatf("v%0d_rdata", i), r.rdata, vecs[i].exp_rdata);
      if (vecs[i].exp_wb > 0) begin
        check($sformatf("v%0d_wb_addr", i), r.wb_addr, vecs[i].exp_wb_addr);
        check($sformatf("v%0d_wb_line", i), r.wb_line, vecs[i].exp_wb_line);
      end
      if (vecs[i].exp_rd > 0) check($sformatf("v%0d_rd_addr", i), r.rd_addr, vecs[i].exp_rd_addr);
      else                    check($sformatf("v%0d_no_ddr", i), r.nreq, 0);
      if (vecs[i].exp_wr > 0) begin
        check($sformatf("v%0d_wr_line", i), r.wr_line, vecs[i].exp_wr_line);
        check($sformatf("v%0d_wr_dirty", i), r.wr_dirty, vecs[i].exp_wr_dirty);
      end
    end

    ddr_wait_cfg = -1;
    for (int i = 0; i < 300; i++) begin
      logic [AW-1:0] a;
      logic          we;
      logic [DW-1:0] d;
      a  = {TW'($urandom_range(0, 3)), IW'($urandom_range(0, 5)), OW'($urandom_range(0, 7))};
      we = 1'($urandom_range(0, 1));
      d  = $urandom;
      ref_access(a, we, d, hit, wb, er);
      do_req(a, we, d, r);
      exp_lat = hit ? 1 : 3 + r.rd_wait + (wb ? 1 + r.wb_wait : 0);
      check($sformatf("rnd%0d_lat", i), r.lat, exp_lat);
      check($sformatf("rnd%0d_nwb", i), r.nwb, wb);
      check($sformatf("rnd%0d_nrd", i), r.nrd, !hit);
      if (!we) check($sformatf("rnd%0d_rdata", i), r.rdata, er);
      if (!hit) check($sformatf("rnd%0d_dirty", i), r.wr_dirty, we);
    end

    // Reset during ALLOCATE followed by a late DDR ack.
    ddr_auto  = 1'b0;
    ack_force = 1'b0;
    @(negedge clk);
    #1;
    wr0 = n_wr; rdy0 = n_ready;
    cpu_addr = 28'h0000030; cpu_re = 1'b1;
    @(negedge clk);
    cpu_re = 1'b0;
    @(negedge clk);
    #1;
    check("t6_mem_re_set", mem_re, 1);
    check("t6_mem_addr", mem_addr, 28'h0000030);
    rst = 1'b1;
    arr_clear = 1'b1;
    @(negedge clk);
    #1;
    check("t6_mem_re_drop", mem_re, 0);
    check("t6_mem_we_low", mem_we, 0);
    rst = 1'b0;
    arr_clear = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 ack_force = 1'b1;
    @(negedge clk);
    #1 ack_force = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("t6_no_write", n_wr - wr0, 0);
    check("t6_no_ready", n_ready - rdy0, 0);
    check("t6_idle_after_ack", mem_re | mem_we, 0);
    ddr_auto = 1'b1;
    ddr_wait_cfg = 1;
    do_req(28'h0000030, 1'b0, '0, r);
    check("t6_repeat_nrd", r.nrd, 1);
    check("t6_repeat_nwb", r.nwb, 0);
    check("t6_repeat_lat", r.lat, 4);
    check("t6_repeat_rdata", r.rdata, 32'h3000);

    check("mem_re_we_exclusive", excl_bad, 0);
    check("rdata_zero_when_idle", rdata_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
